pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the fetch stage, successor to the fixed one-delay-slot PC unit. It produces the fetch address each cycle. It supports a configurable number of branch delay slots (0–3), a fetch stall, a high-priority trap/flush redirect, and target alignment checking. It sits between the branch-resolution logic and the instruction-memory address port.

## Interface
- XLEN, 32, address width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset; must be STEP-aligned
- STEP, 4, sequential increment in bytes (power of two, 2 or 4)
- DELAY_SLOTS, 1, sequential instructions executed after a taken branch before the target (0–3)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold current PC; freezes the delay-slot counter
- branch  in  1  taken branch resolved for the instruction at current pc
- branch_addr  in  XLEN  branch target
- redirect  in  1  trap/flush; overrides branch and stall
- redirect_addr  in  XLEN  redirect target
- pc  out  XLEN  current fetch address
- pc_plus_step  out  XLEN  pc + STEP, combinational, modulo 2^XLEN
- in_delay_slot  out  1  current pc is a delay-slot fetch (a branch target is pending)
- branch_dropped  out  1  one-cycle pulse: branch ignored because one was already pending
- target_misaligned  out  1  one-cycle pulse: accepted target had nonzero bits below log2(STEP)

## Operation
- State: pc_reg (XLEN), pend_valid (1), pend_addr (XLEN), slot_cnt (2 bits).
- Reset (rst=1 at edge): pc_reg=RESET_VECTOR, pend_valid=0, slot_cnt=0, both pulse outputs 0. Reset wins over every other input.
- Priority per edge: rst > redirect > stall > pending/branch > sequential.
- redirect=1: pc_reg=redirect_addr with low bits forced to 0. pend_valid is cleared, so no delay slots follow. target_misaligned pulses if the low bits were nonzero. Stall is ignored.
- stall=1 (no redirect): all state holds. branch is not sampled; upstream holds branch high until stall drops.
- branch=1 with pend_valid=0, DELAY_SLOTS=0: pc_reg=aligned branch_addr next edge.
- branch=1 with pend_valid=0, DELAY_SLOTS=N>0: pend_addr=aligned branch_addr, pend_valid=1, slot_cnt=N−1, pc_reg=pc_reg+STEP.
- pend_valid=1, slot_cnt>0: pc_reg=pc_reg+STEP, slot_cnt−1.
- pend_valid=1, slot_cnt=0: pc_reg=pend_addr, pend_valid=0.
- branch=1 while pend_valid=1 (branch in a delay slot): the branch is ignored, branch_dropped pulses, and the sequence continues unchanged.
- No pending target, no branch: pc_reg=pc_reg+STEP.
- Alignment: a target is masked to a STEP boundary. target_misaligned pulses in the cycle after acceptance, aligned with the edge that latched the target.
- Arithmetic: all additions are modulo 2^XLEN. For example, pc=0xFFFF_FFFC with STEP=4 wraps to 0x0000_0000 with no flag.
- in_delay_slot = pend_valid (registered).

## Timing
- pc is a registered output. It changes only on a rising clk edge.
- Taken-branch latency: the target appears on pc DELAY_SLOTS+1 edges after the edge that samples branch.
- Redirect latency: 1 edge, regardless of pending state or stall.
- A stall cycle during delay slots extends the sequence by one cycle. The slot count is not consumed.
- pc_plus_step is combinational from pc_reg and adds zero latency.
- Both pulses last exactly one cycle. They are registered and are 0 in the cycle after reset.
- Reset mid-sequence discards any pending target.

## Test plan
- Reset, then free run (DELAY_SLOTS=1, RESET_VECTOR=0x100) -> pc = 0x100, 0x104, 0x108 on successive cycles. in_delay_slot=0 throughout.
- DELAY_SLOTS=2: branch=1 to 0x400 while pc=0x10 -> pc = 0x14, 0x18, 0x400. in_delay_slot=1 for the 0x14 and 0x18 cycles. DELAY_SLOTS=0, same stimulus -> pc = 0x400 next cycle.
- DELAY_SLOTS=1: branch to 0x200 at pc=0x20, stall held 2 cycles during the slot -> pc = 0x24, 0x24, 0x24, 0x200. A second branch to 0x300 at pc=0x24 is ignored and branch_dropped pulses once.
- Redirect to 0x8000 while a branch target is pending and stall=1 -> pc=0x8000 next cycle, in_delay_slot=0, and the pending target never appears. branch_addr=0x403 -> pc=0x400 and target_misaligned pulses.
- pc=0xFFFF_FFF8, free run -> pc = 0xFFFF_FFFC, 0x0000_0000. rst asserted mid-delay-slot -> pc=RESET_VECTOR next cycle and the pending target is discarded.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-PC bus: redirect/branch/stall controls in, fetch address and status out.
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            branch;
    logic [XLEN-1:0] branch_addr;
    logic            redirect;
    logic [XLEN-1:0] redirect_addr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_step;
    logic            in_delay_slot;
    logic            branch_dropped;
    logic            target_misaligned;

    modport master (
        output stall, branch, branch_addr, redirect, redirect_addr,
        input  pc, pc_plus_step, in_delay_slot, branch_dropped, target_misaligned
    );

    modport slave (
        input  stall, branch, branch_addr, redirect, redirect_addr,
        output pc, pc_plus_step, in_delay_slot, branch_dropped, target_misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator with 0-3 branch delay slots, stall,
// priority trap/flush redirect and target alignment masking.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter int              DELAY_SLOTS  = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    pc_gen_if.slave  io_bus
);
    localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] STEP_X    = XLEN'(STEP);
    localparam logic [1:0]      SLOT_INIT = (DELAY_SLOTS > 0) ? 2'(DELAY_SLOTS - 1) : 2'd0;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pend_addr;
    logic            r_pend_valid;
    logic [1:0]      r_slot_cnt;
    logic            r_branch_dropped;
    logic            r_target_misaligned;

    logic [XLEN-1:0] w_pc_next_seq;
    logic [XLEN-1:0] w_branch_al;
    logic [XLEN-1:0] w_redirect_al;
    logic            w_branch_low;
    logic            w_redirect_low;

    assign w_pc_next_seq  = r_pc + STEP_X;
    assign w_branch_al    = io_bus.branch_addr & ~LOW_MASK;
    assign w_redirect_al  = io_bus.redirect_addr & ~LOW_MASK;
    assign w_branch_low   = |(io_bus.branch_addr & LOW_MASK);
    assign w_redirect_low = |(io_bus.redirect_addr & LOW_MASK);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc                <= RESET_VECTOR;
            r_pend_addr         <= '0;
            r_pend_valid        <= 1'b0;
            r_slot_cnt          <= 2'd0;
            r_branch_dropped    <= 1'b0;
            r_target_misaligned <= 1'b0;
        end else begin
            r_branch_dropped    <= 1'b0;
            r_target_misaligned <= 1'b0;
            if (io_bus.redirect) begin
                // Trap/flush discards any pending target and ignores stall.
                r_pc                <= w_redirect_al;
                r_pend_valid        <= 1'b0;
                r_slot_cnt          <= 2'd0;
                r_target_misaligned <= w_redirect_low;
            end else if (!io_bus.stall) begin
                if (r_pend_valid) begin
                    r_branch_dropped <= io_bus.branch;
                    if (r_slot_cnt != 2'd0) begin
                        r_pc       <= w_pc_next_seq;
                        r_slot_cnt <= r_slot_cnt - 2'd1;
                    end else begin
                        r_pc         <= r_pend_addr;
                        r_pend_valid <= 1'b0;
                    end
                end else if (io_bus.branch) begin
                    r_target_misaligned <= w_branch_low;
                    if (DELAY_SLOTS == 0) begin
                        r_pc <= w_branch_al;
                    end else begin
                        r_pend_addr  <= w_branch_al;
                        r_pend_valid <= 1'b1;
                        r_slot_cnt   <= SLOT_INIT;
                        r_pc         <= w_pc_next_seq;
                    end
                end else begin
                    r_pc <= w_pc_next_seq;
                end
            end
        end
    end

    assign io_bus.pc                = r_pc;
    assign io_bus.pc_plus_step      = w_pc_next_seq;
    assign io_bus.in_delay_slot     = r_pend_valid;
    assign io_bus.branch_dropped    = r_branch_dropped;
    assign io_bus.target_misaligned = r_target_misaligned;
endmodule
